// File: rtl/dds_axi_pkg.sv
// Shared constants for the DDS status read port.
// Word indices, response codes, ID default and FSM encoding.
package dds_axi_pkg;

  localparam logic [31:0] ID_WORD_DEF = 32'hDD50_0001;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] WI_ID     = 4'd0;
  localparam logic [3:0] WI_FSQ1   = 4'd1;
  localparam logic [3:0] WI_FSQ2   = 4'd2;
  localparam logic [3:0] WI_PSQ1   = 4'd3;
  localparam logic [3:0] WI_PSQ2   = 4'd4;
  localparam logic [3:0] WI_FSIN   = 4'd5;
  localparam logic [3:0] WI_PSIN   = 4'd6;
  localparam logic [3:0] WI_ASIN   = 4'd7;
  localparam logic [3:0] WI_FSAW   = 4'd8;
  localparam logic [3:0] WI_ASAW   = 4'd9;
  localparam logic [3:0] WI_DC1    = 4'd10;
  localparam logic [3:0] WI_DC2    = 4'd11;
  localparam logic [3:0] WI_DLYSAW = 4'd12;
  localparam logic [3:0] WI_OUTEN  = 4'd13;
  localparam logic [3:0] WI_FRAME  = 4'd14;
  localparam logic [3:0] WI_SQCNT  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACPT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dds_edge_cnt.sv
// Rising-edge detector feeding a free-running wrap counter.
// Ports: clk, rst_n (sync, active-low), sig in, cnt out.
module dds_edge_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig,
  output logic [CNT_W-1:0] cnt
);

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  always_comb begin
    rise   = sig & ~prev_q;
    prev_d = sig;
    cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, rise};
  end

  // prev resets high so a level held across reset release is not an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dds_axi_rd.sv
// AXI-lite style read-only status port for the DDS block.
// Ports: AR/R channel, live DDS control words, cs_n/square_1x.
module dds_axi_rd
  import dds_axi_pkg::*;
#(
  parameter logic [31:0] ID_WORD = ID_WORD_DEF,
  parameter int          CNT_W   = 32
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        s_axi_arvalid,
  input  logic [5:0]  s_axi_araddr,
  output logic        s_axi_arready,
  output logic        s_axi_rvalid,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  input  logic        s_axi_rready,
  input  logic [31:0] freq_square_1x,
  input  logic [31:0] freq_square_2x,
  input  logic [31:0] phase_square_1x,
  input  logic [31:0] phase_square_2x,
  input  logic [31:0] freq_sin,
  input  logic [31:0] phase_sin_init,
  input  logic [31:0] freq_saw,
  input  logic [31:0] dc_data1,
  input  logic [31:0] dc_data2,
  input  logic [31:0] delay_saw,
  input  logic [15:0] amp_sin,
  input  logic [15:0] amp_saw,
  input  logic        out_en,
  input  logic        cs_n,
  input  logic        square_1x
);

  state_e      state_q, state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [5:0]  addr_q, addr_d;

  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] sq_cnt;
  logic [31:0]      sel_word;

  dds_edge_cnt #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .sig   (cs_n),
    .cnt   (frame_cnt)
  );

  dds_edge_cnt #(.CNT_W(CNT_W)) u_sq_cnt (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .sig   (square_1x),
    .cnt   (sq_cnt)
  );

  always_comb begin
    sel_word = '0;
    case (addr_q[5:2])
      WI_ID:     sel_word = ID_WORD;
      WI_FSQ1:   sel_word = freq_square_1x;
      WI_FSQ2:   sel_word = freq_square_2x;
      WI_PSQ1:   sel_word = phase_square_1x;
      WI_PSQ2:   sel_word = phase_square_2x;
      WI_FSIN:   sel_word = freq_sin;
      WI_PSIN:   sel_word = phase_sin_init;
      WI_ASIN:   sel_word = {16'h0, amp_sin};
      WI_FSAW:   sel_word = freq_saw;
      WI_ASAW:   sel_word = {16'h0, amp_saw};
      WI_DC1:    sel_word = dc_data1;
      WI_DC2:    sel_word = dc_data2;
      WI_DLYSAW: sel_word = delay_saw;
      WI_OUTEN:  sel_word = {31'h0, out_en};
      WI_FRAME:  sel_word = 32'(frame_cnt);
      WI_SQCNT:  sel_word = 32'(sq_cnt);
      default:   sel_word = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    addr_d    = addr_q;
    case (state_q)
      ST_IDLE: begin
        arready_d = 1'b0;
        if (s_axi_arvalid) begin
          arready_d = 1'b1;
          addr_d    = s_axi_araddr;
          state_d   = ST_ACPT;
        end
      end
      ST_ACPT: begin
        arready_d = 1'b0;
        rvalid_d  = 1'b1;
        state_d   = ST_RESP;
        // counters read here are pre-increment if an edge lands now
        if (addr_q[1:0] != 2'b00) begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end else begin
          rdata_d = sel_word;
          rresp_d = RESP_OKAY;
        end
      end
      ST_RESP: begin
        if (s_axi_rready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      addr_q    <= addr_d;
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_dds_axi_rd.sv
// Directed bench for dds_axi_rd.
// Checks latency, word map, SLVERR, snapshot, counters, reset.
module tb_dds_axi_rd;

  logic        clk = 1'b0;
  logic        rstn;
  logic        arvalid;
  logic [5:0]  araddr;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rready;
  logic [31:0] fsq1, fsq2, psq1, psq2, fsin, psin, fsaw;
  logic [31:0] dc1, dc2, dlysaw;
  logic [15:0] asin, asaw;
  logic        outen;
  logic        cs_n;
  logic        sq1;
  logic        wsig;
  logic [3:0]  wcnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] d;
  logic [1:0]  r;

  always #5 clk = ~clk;

  dds_axi_rd dut (
    .s_axi_aclk      (clk),
    .s_axi_aresetn   (rstn),
    .s_axi_arvalid   (arvalid),
    .s_axi_araddr    (araddr),
    .s_axi_arready   (arready),
    .s_axi_rvalid    (rvalid),
    .s_axi_rdata     (rdata),
    .s_axi_rresp     (rresp),
    .s_axi_rready    (rready),
    .freq_square_1x  (fsq1),
    .freq_square_2x  (fsq2),
    .phase_square_1x (psq1),
    .phase_square_2x (psq2),
    .freq_sin        (fsin),
    .phase_sin_init  (psin),
    .freq_saw        (fsaw),
    .dc_data1        (dc1),
    .dc_data2        (dc2),
    .delay_saw       (dlysaw),
    .amp_sin         (asin),
    .amp_saw         (asaw),
    .out_en          (outen),
    .cs_n            (cs_n),
    .square_1x       (sq1)
  );

  // narrow copy of the counter so the wrap can be reached quickly
  dds_edge_cnt #(.CNT_W(4)) u_wrap (
    .clk   (clk),
    .rst_n (rstn),
    .sig   (wsig),
    .cnt   (wcnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // mode 1: change amp_sin while waiting in RESP
  // mode 2: raise square_1x during the ACPT cycle
  task automatic rd(input logic [5:0] a, input int wait_n,
                    input int mode,
                    output logic [31:0] od, output logic [1:0] orr);
    @(negedge clk);
    arvalid = 1'b1;
    araddr  = a;
    @(negedge clk);
    chk("arready_n1", {31'h0, arready}, 32'h1);
    chk("rvalid_n1", {31'h0, rvalid}, 32'h0);
    arvalid = 1'b0;
    if (mode == 2) sq1 = 1'b1;
    @(negedge clk);
    chk("rvalid_n2", {31'h0, rvalid}, 32'h1);
    chk("arready_n2", {31'h0, arready}, 32'h0);
    od  = rdata;
    orr = rresp;
    for (int i = 0; i < wait_n; i++) begin
      if (mode == 1 && i == 2) asin = 16'h1234;
      @(negedge clk);
      chk("rvalid_hold", {31'h0, rvalid}, 32'h1);
      chk("rdata_hold", rdata, od);
    end
    rready = 1'b1;
    @(negedge clk);
    chk("rvalid_n3", {31'h0, rvalid}, 32'h0);
    rready = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; arvalid = 1'b0; araddr = '0; rready = 1'b0;
    fsq1 = 32'h1111_0001; fsq2 = 32'h2222_0002;
    psq1 = 32'h3333_0003; psq2 = 32'h4444_0004;
    fsin = 32'h5555_0005; psin = 32'h6666_0006;
    fsaw = 32'h7777_0008; dc1 = 32'h8888_000A;
    dc2 = 32'h9999_000B; dlysaw = 32'hAAAA_000C;
    asin = 16'hABCD; asaw = 16'hF00D; outen = 1'b1;
    cs_n = 1'b1; sq1 = 1'b1; wsig = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_arready", {31'h0, arready}, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rresp", {30'h0, rresp}, 32'h0);
    rstn = 1'b1;

    rd(6'h00, 0, 0, d, r);
    chk("id_data", d, 32'hDD50_0001);
    chk("id_resp", {30'h0, r}, 32'h0);

    rd(6'h1C, 5, 1, d, r);
    chk("amp_sin", d, 32'h0000_ABCD);
    chk("amp_sin_resp", {30'h0, r}, 32'h0);
    rd(6'h1C, 0, 0, d, r);
    chk("amp_sin_new", d, 32'h0000_1234);

    rd(6'h05, 0, 0, d, r);
    chk("slverr_resp", {30'h0, r}, 32'h2);
    chk("slverr_data", d, 32'h0);
    rd(6'h04, 0, 0, d, r);
    chk("fsq1_data", d, 32'h1111_0001);
    chk("fsq1_resp", {30'h0, r}, 32'h0);

    rd(6'h24, 0, 0, d, r);
    chk("amp_saw", d, 32'h0000_F00D);
    rd(6'h34, 0, 0, d, r);
    chk("out_en", d, 32'h0000_0001);
    rd(6'h30, 0, 0, d, r);
    chk("delay_saw", d, 32'hAAAA_000C);
    rd(6'h2C, 1, 0, d, r);
    chk("dc_data2", d, 32'h9999_000B);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk); cs_n = 1'b0;
      @(negedge clk); cs_n = 1'b1;
    end
    rd(6'h38, 0, 0, d, r);
    chk("frame_cnt3", d, 32'h3);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk); sq1 = 1'b0;
      @(negedge clk); sq1 = 1'b1;
    end
    @(negedge clk); sq1 = 1'b0;
    rd(6'h3C, 0, 2, d, r);
    chk("sq_pre_inc", d, 32'h2);
    rd(6'h3C, 0, 0, d, r);
    chk("sq_post_inc", d, 32'h3);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk); wsig = 1'b0;
      @(negedge clk); wsig = 1'b1;
    end
    @(negedge clk);
    chk("wrap_max", {28'h0, wcnt}, 32'hF);
    wsig = 1'b0;
    @(negedge clk); wsig = 1'b1;
    @(negedge clk);
    chk("wrap_zero", {28'h0, wcnt}, 32'h0);

    @(negedge clk);
    arvalid = 1'b1; araddr = 6'h3C;
    @(negedge clk); arvalid = 1'b0;
    @(negedge clk);
    chk("pre_rst_rvalid", {31'h0, rvalid}, 32'h1);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("mid_rst_arready", {31'h0, arready}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_rvalid", {31'h0, rvalid}, 32'h0);
    rd(6'h3C, 0, 0, d, r);
    chk("sq_after_rst", d, 32'h0);
    rd(6'h38, 0, 0, d, r);
    chk("frame_after_rst", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dds_axi_rd.md
DDS_AXI_RD -- requirements
Module: dds_axi_rd

Interface
REQ-001 SHALL have parameter ID_WORD, default 32'hDD50_0001, constant returned at word index 0.
REQ-002 SHALL have parameter CNT_W, default 32, width of both status counters (fixed at 32 in this revision).
REQ-003 SHALL have port s_axi_aclk  in  1  single clock for all logic.
REQ-004 SHALL have port s_axi_aresetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port s_axi_arvalid  in  1  read-address valid.
REQ-006 SHALL have port s_axi_araddr  in  6  byte address; word index = araddr[5:2].
REQ-007 SHALL have port s_axi_arready  out  1  read-address accept, registered.
REQ-008 SHALL have port s_axi_rvalid  out  1  read-data valid, registered.
REQ-009 SHALL have port s_axi_rdata  out  32  read data, registered.
REQ-010 SHALL have port s_axi_rresp  out  2  read response (00 OKAY, 10 SLVERR).
REQ-011 SHALL have port s_axi_rready  in  1  master data accept.
REQ-012 SHALL have ports freq_square_1x, freq_square_2x, phase_square_1x, phase_square_2x, freq_sin, phase_sin_init, freq_saw, dc_data1, dc_data2, delay_saw  in  32 each  live DDS control words.
REQ-013 SHALL have ports amp_sin, amp_saw  in  16 each; out_en  in  1  live DDS control words.
REQ-014 SHALL have ports cs_n, square_1x  in  1 each  DDS SPI chip-select and square output, same clock domain.

Function
REQ-015 SHALL map word index: 0 ID_WORD; 1 freq_square_1x; 2 freq_square_2x; 3 phase_square_1x; 4 phase_square_2x; 5 freq_sin; 6 phase_sin_init; 7 amp_sin; 8 freq_saw; 9 amp_saw; 10 dc_data1; 11 dc_data2; 12 delay_saw; 13 out_en; 14 frame_cnt; 15 sq_cnt.
REQ-016 SHALL zero-extend amp_sin, amp_saw (to bit 15) and out_en (bit 0) into rdata.
REQ-017 SHALL use FSM IDLE -> ACPT -> RESP -> IDLE.
REQ-018 IDLE: on arvalid=1, arready<=1, latch araddr, go ACPT; else arready<=0.
REQ-019 ACPT: arready<=0, rdata<=selected word, rresp<=OKAY, rvalid<=1, go RESP.
REQ-020 RESP: hold rvalid, rdata, rresp stable until rready=1; then rvalid<=0, go IDLE.
REQ-021 Latency: arvalid seen cycle N -> arready high N+1, rvalid high N+2; rready already high at N+2 -> rvalid low N+3.
REQ-022 Next arvalid SHALL be accepted no earlier than the first IDLE cycle after RESP; back-to-back reads take 3 cycles minimum each.
REQ-023 araddr[1:0]!=0 SHALL return rresp=SLVERR, rdata=0, same timing as OKAY reads.
REQ-024 rdata SHALL be a snapshot taken in ACPT; input changes during RESP SHALL NOT alter it.
REQ-025 frame_cnt SHALL increment by 1 on each cs_n rising edge (prev 0, now 1); sq_cnt likewise on square_1x rising edges.
REQ-026 Counters SHALL wrap FFFF_FFFF -> 0000_0000 without flag; they are free-running and not cleared on read.
REQ-027 A counter increment in the same cycle as ACPT SHALL yield the pre-increment value in rdata.
REQ-028 Block SHALL have no write channel and no effect on DDS control words.

Reset
REQ-029 While s_axi_aresetn=0 at a clock edge: state IDLE, arready=0, rvalid=0, rdata=0, rresp=00, counters=0.
REQ-030 Edge-detect previous-value registers SHALL reset to 1 so no edge is counted from levels present at reset release.
REQ-031 Reset asserted mid-transaction SHALL drop rvalid/arready at the next edge and discard the pending read.

Structure
REQ-032 Shared package dds_axi_pkg SHALL hold word-index constants, ID_WORD default, RESP_OKAY/RESP_SLVERR codes, FSM state encoding.
REQ-033 Sub-module dds_edge_cnt (rising-edge detect + CNT_W wrap counter, sync active-low reset) SHALL be instantiated twice.

Verification
REQ-034 Read araddr=0x00, rready=1 -> arready N+1, rvalid N+2, rdata=DD50_0001, rresp=00.
REQ-035 amp_sin=16'hABCD, read 0x1C with rready low 5 cycles, change amp_sin mid-wait -> rdata=0000_ABCD held stable until rready.
REQ-036 Read 0x05 -> rresp=10, rdata=0; following read 0x04 -> rresp=00, rdata=freq_square_1x.
REQ-037 Pulse cs_n low/high 3 times, read 0x38 -> rdata=3; force counter to FFFF_FFFF, one more edge -> 0.
REQ-038 Reset during RESP -> rvalid=0 next edge; sq_cnt read afterwards =0; no edge counted at reset release with square_1x high.
